// File: rtl/byte_gather_pkg.sv
// Shared lane definitions for the 4-lane byte serializer and byte gatherer.
package byte_gather_pkg;

   localparam int WIDTH_DEF = 8;
   localparam int LANES     = 4;

   typedef enum logic [1:0] {
      L0 = 2'd0,
      L1 = 2'd1,
      L2 = 2'd2,
      L3 = 2'd3
   } lane_state_t;

   // Unknown-state initializer; kept beside the enum so it can carry X without aliasing L0
   localparam logic [1:0] XX = 2'bxx;

   typedef logic [WIDTH_DEF-1:0] lane_word_t [0:LANES-1];

endpackage

// File: rtl/byte_gather_fsm_if.sv
// Serial byte input stream plus lane-parallel word output stream of the byte gatherer.
interface byte_gather_fsm_if #(parameter int WIDTH = 8);
   import byte_gather_pkg::*;

   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_sof;
   logic             in_ready;
   logic [WIDTH-1:0] out_data [0:LANES-1];
   logic             out_valid;
   logic             out_ready;

   modport master (
      output in_valid, in_data, in_sof, out_ready,
      input  in_ready, out_data, out_valid
   );

   modport slave (
      input  in_valid, in_data, in_sof, out_ready,
      output in_ready, out_data, out_valid
   );

endinterface

// File: rtl/byte_gather_fsm.sv
// Reassembles a serial byte stream into 4-lane words, lane 0 = first byte.
// Optional BYTE_GATHER_ERR_EN adds frame_err / drop_cnt discard reporting.
//
// state | meaning
// L0    | waiting for lane 0 byte
// L1    | lane 0 held, waiting for lane 1
// L2    | lanes 0-1 held, waiting for lane 2
// L3    | lanes 0-2 held, next beat completes the word
module byte_gather_fsm
   import byte_gather_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       reset,
`ifdef BYTE_GATHER_ERR_EN
   output logic       frame_err,
   output logic [7:0] drop_cnt,
`endif
   byte_gather_fsm_if.slave bus
);

   localparam logic [1:0] S_L0 = L0;
   localparam logic [1:0] S_L1 = L1;
   localparam logic [1:0] S_L2 = L2;
   localparam logic [1:0] S_L3 = L3;
   localparam logic [1:0] S_XX = XX;

   logic [1:0]       r_state;
   logic [1:0]       w_next;
   logic             w_in_ready;
   logic             w_beat;
   logic             w_word_done;
   logic [WIDTH-1:0] r_asm      [0:LANES-2];
   logic [WIDTH-1:0] r_out_data [0:LANES-1];
   logic             r_out_valid;

   // Stall only when the completing beat would overwrite an unconsumed word
   always_comb begin
      w_in_ready = 1'b1;
      unique case (r_state)
         S_L0, S_L1, S_L2: w_in_ready = 1'b1;
         S_L3:             w_in_ready = !(r_out_valid && !bus.out_ready);
         default:          w_in_ready = 1'bx;
      endcase
   end

   assign w_beat      = bus.in_valid && w_in_ready;
   assign w_word_done = w_beat && !bus.in_sof && (r_state == S_L3);

   // in_sof always restarts the frame with this byte in lane 0
   always_comb begin
      w_next = S_XX;
      unique case (r_state)
         S_L0:    w_next = w_beat ? S_L1 : S_L0;
         S_L1:    w_next = w_beat ? (bus.in_sof ? S_L1 : S_L2) : S_L1;
         S_L2:    w_next = w_beat ? (bus.in_sof ? S_L1 : S_L3) : S_L2;
         S_L3:    w_next = w_beat ? (bus.in_sof ? S_L1 : S_L0) : S_L3;
         default: w_next = S_XX;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_L0;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_asm       <= '{default: '0};
         r_out_data  <= '{default: '0};
         r_out_valid <= 1'b0;
      end else begin
         if (w_word_done) begin
            r_out_data  <= '{r_asm[0], r_asm[1], r_asm[2], bus.in_data};
            r_out_valid <= 1'b1;
         end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_beat) begin
            if (bus.in_sof) begin
               r_asm[0] <= bus.in_data;
            end else begin
               unique case (r_state)
                  S_L0:    r_asm[0] <= bus.in_data;
                  S_L1:    r_asm[1] <= bus.in_data;
                  S_L2:    r_asm[2] <= bus.in_data;
                  S_L3:    ;
                  default: r_asm <= '{default: 'x};
               endcase
            end
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign bus.out_data[g] = r_out_data[g];
   end

`ifdef BYTE_GATHER_ERR_EN
   logic w_discard;

   assign w_discard = w_beat && bus.in_sof && (r_state != S_L0);

   always_ff @(posedge clk) begin
      if (reset) begin
         frame_err <= 1'b0;
         drop_cnt  <= 8'd0;
      end else if (w_discard) begin
         frame_err <= 1'b1;
         if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_byte_gather_fsm.sv
// Scoreboarded bench for byte_gather_fsm: expected words queued at stimulus, checked on consumption.
module tb_byte_gather_fsm;
   import byte_gather_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   byte_gather_fsm_if #(.WIDTH(8)) bus ();

`ifdef BYTE_GATHER_ERR_EN
   logic       frame_err;
   logic [7:0] drop_cnt;
`endif

   byte_gather_fsm #(.WIDTH(8)) dut (
      .clk      (clk),
      .reset    (reset),
`ifdef BYTE_GATHER_ERR_EN
      .frame_err(frame_err),
      .drop_cnt (drop_cnt),
`endif
      .bus      (bus)
   );

   int          checks = 0;
   int          errors = 0;
   int          valid_cycles = 0;
   logic [31:0] sb [$];
   logic [31:0] mon_got;
   logic [31:0] mon_exp;

   function automatic logic [31:0] word_now();
      return {bus.out_data[0], bus.out_data[1], bus.out_data[2], bus.out_data[3]};
   endfunction

   always @(negedge clk) begin
      if (!reset && bus.out_valid) valid_cycles++;
      if (!reset && bus.out_valid && bus.out_ready) begin
         mon_got = word_now();
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_word got=%h expected=none", mon_got);
         end else begin
            mon_exp = sb.pop_front();
            if (mon_got !== mon_exp) begin
               errors++;
               $display("FAIL sb_word got=%h expected=%h", mon_got, mon_exp);
            end
         end
      end
   end

   // Presents one byte and waits for it to be accepted; returns aligned at posedge+1
   task automatic send(input logic [7:0] d, input logic sof, output int stalls);
      logic rdy;
      stalls = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_sof   = sof;
      forever begin
         @(negedge clk);
         rdy = bus.in_ready;
         @(posedge clk);
         if (rdy) break;
         stalls++;
         if (stalls > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout data=%h stalls=%0d required=accept", d, stalls);
            break;
         end
      end
      #1;
      bus.in_valid = 1'b0;
      bus.in_sof   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      // intentionally unused helper avoided; kept out of the flow
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_sof    = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_out_valid got=%b expected=0", bus.out_valid);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got=%b expected=1", bus.in_ready);
      end
      checks++;
      if (word_now() !== 32'h0) begin
         errors++; $display("FAIL reset_out_data got=%h expected=00000000", word_now());
      end
      checks++;
      if (dut.r_state !== 2'd0) begin
         errors++; $display("FAIL reset_state got=%0d expected=0", dut.r_state);
      end
`ifdef BYTE_GATHER_ERR_EN
      checks++;
      if (frame_err !== 1'b0 || drop_cnt !== 8'd0) begin
         errors++; $display("FAIL reset_err got=%b/%0d expected=0/0", frame_err, drop_cnt);
      end
`endif
   endtask

   task automatic test_single();
      int s, tot;
      logic [7:0] bytes [4];
      bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
      tot = 0;
      bus.out_ready = 1'b1;
      sb.push_back(32'h11223344);
      for (int i = 0; i < 4; i++) begin
         send(bytes[i], 1'b0, s);
         tot += s;
      end
      checks++;
      if (bus.out_valid !== 1'b1) begin
         errors++; $display("FAIL single_latency out_valid got=%b expected=1", bus.out_valid);
      end
      checks++;
      if (word_now() !== 32'h11223344) begin
         errors++; $display("FAIL single_data got=%h expected=11223344", word_now());
      end
      checks++;
      if (dut.r_state !== 2'd0) begin
         errors++; $display("FAIL single_state got=%0d expected=0", dut.r_state);
      end
      idle(1);
      checks++;
      if (bus.out_valid !== 1'b0 || tot != 0) begin
         errors++; $display("FAIL single_drain out_valid=%b stalls=%0d expected 0/0", bus.out_valid, tot);
      end
   endtask

   task automatic test_stream();
      int s, tot, vc0;
      tot = 0;
      vc0 = valid_cycles;
      bus.out_ready = 1'b1;
      sb.push_back(32'h00010203);
      sb.push_back(32'h04050607);
      for (int i = 0; i < 8; i++) begin
         send(8'(i), 1'b0, s);
         tot += s;
      end
      idle(2);
      checks++;
      if (tot != 0) begin
         errors++; $display("FAIL stream_stalls got=%0d expected=0", tot);
      end
      checks++;
      if (valid_cycles - vc0 != 2) begin
         errors++; $display("FAIL stream_valid_cycles got=%0d expected=2", valid_cycles - vc0);
      end
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL stream_pending got=%0d expected=0", sb.size());
      end
   endtask

   task automatic test_backpressure();
      int s, tot;
      tot = 0;
      bus.out_ready = 1'b0;
      sb.push_back(32'hA0A1A2A3);
      sb.push_back(32'hA4A5A6A7);
      for (int i = 0; i < 7; i++) begin
         send(8'hA0 + 8'(i), 1'b0, s);
         tot += s;
      end
      checks++;
      if (tot != 0) begin
         errors++; $display("FAIL bp_early_stalls got=%0d expected=0", tot);
      end
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hA7;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_in_ready cycle=%0d got=%b expected=0", i, bus.in_ready);
         end
         checks++;
         if (bus.out_valid !== 1'b1 || word_now() !== 32'hA0A1A2A3) begin
            errors++; $display("FAIL bp_hold cycle=%0d got=%b/%h expected=1/a0a1a2a3", i, bus.out_valid, word_now());
         end
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release_in_ready got=%b expected=1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || word_now() !== 32'hA4A5A6A7) begin
         errors++; $display("FAIL bp_reload got=%b/%h expected=1/a4a5a6a7", bus.out_valid, word_now());
      end
      checks++;
      if (dut.r_state !== 2'd0) begin
         errors++; $display("FAIL bp_state got=%0d expected=0", dut.r_state);
      end
      bus.out_ready = 1'b1;
      idle(2);
      checks++;
      if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
         errors++; $display("FAIL bp_drain pending=%0d out_valid=%b expected 0/0", sb.size(), bus.out_valid);
      end
   endtask

   task automatic test_resync();
      int s;
      bus.out_ready = 1'b1;
      sb.push_back(32'h10111213);
      send(8'h01, 1'b1, s);
      send(8'h02, 1'b0, s);
      send(8'h10, 1'b1, s);
      send(8'h11, 1'b0, s);
      send(8'h12, 1'b0, s);
      send(8'h13, 1'b0, s);
      idle(1);
`ifdef BYTE_GATHER_ERR_EN
      checks++;
      if (frame_err !== 1'b1 || drop_cnt !== 8'd1) begin
         errors++; $display("FAIL resync_err1 got=%b/%0d expected=1/1", frame_err, drop_cnt);
      end
`endif
      sb.push_back(32'h23242526);
      send(8'h20, 1'b0, s);
      send(8'h21, 1'b0, s);
      send(8'h22, 1'b0, s);
      send(8'h23, 1'b1, s);
      checks++;
      if (bus.out_valid !== 1'b0 || dut.r_state !== 2'd1) begin
         errors++; $display("FAIL resync_l3 out_valid=%b state=%0d expected 0/1", bus.out_valid, dut.r_state);
      end
      send(8'h24, 1'b0, s);
      send(8'h25, 1'b0, s);
      send(8'h26, 1'b0, s);
      idle(2);
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL resync_pending got=%0d expected=0", sb.size());
      end
`ifdef BYTE_GATHER_ERR_EN
      checks++;
      if (frame_err !== 1'b1 || drop_cnt !== 8'd2) begin
         errors++; $display("FAIL resync_err2 got=%b/%0d expected=1/2", frame_err, drop_cnt);
      end
`endif
   endtask

   task automatic test_reset_mid();
      int s;
      logic [7:0] b;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         b = 8'h30 + 8'(i);
         send(b, 1'b0, s);
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || word_now() !== 32'h0 || dut.r_state !== 2'd0) begin
         errors++; $display("FAIL rstmid_clear got=%b/%h/%0d expected=0/00000000/0", bus.out_valid, word_now(), dut.r_state);
      end
`ifdef BYTE_GATHER_ERR_EN
      checks++;
      if (frame_err !== 1'b0 || drop_cnt !== 8'd0) begin
         errors++; $display("FAIL rstmid_err got=%b/%0d expected=0/0", frame_err, drop_cnt);
      end
`endif
      bus.out_ready = 1'b1;
      sb.push_back(32'h5A5B5C5D);
      for (int i = 0; i < 3; i++) begin
         b = 8'h5A + 8'(i);
         send(b, 1'b0, s);
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_early_valid beat=%0d got=%b expected=0", i, bus.out_valid);
         end
      end
      send(8'h5D, 1'b0, s);
      checks++;
      if (bus.out_valid !== 1'b1 || word_now() !== 32'h5A5B5C5D) begin
         errors++; $display("FAIL rstmid_word got=%b/%h expected=1/5a5b5c5d", bus.out_valid, word_now());
      end
      idle(1);
   endtask

   task automatic test_gaps();
      int s;
      logic [7:0] b;
      logic [1:0] st;
      bus.out_ready = 1'b1;
      sb.push_back(32'hC0C1C2C3);
      for (int i = 0; i < 4; i++) begin
         b = 8'hC0 + 8'(i);
         send(b, 1'b0, s);
         idle(1);
         st = 2'(i + 1);
         checks++;
         if (dut.r_state !== st) begin
            errors++; $display("FAIL gaps_state beat=%0d got=%0d expected=%0d", i, dut.r_state, st);
         end
      end
      idle(1);
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL gaps_pending got=%0d expected=0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_resync();
      test_reset_mid();
      test_gaps();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
